// File: rtl/logical_tile_io_bank_cfg.sv
// logical_tile_io_bank_cfg: serially configured GPIO pad bank; define GPIO_SHADOW_EN to apply config through a load-strobed shadow register
module logical_tile_io_bank_cfg #(
    parameter int NUM_PAD = 4,
    localparam int CFG_BITS = 3,
    localparam int L = CFG_BITS * NUM_PAD,
    localparam int CNT_W = $clog2(L + 1)
) (
    input  logic               prog_clk,
    input  logic               pReset,
    inout  wire  [NUM_PAD-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_PAD-1:0] iopad_outpad,
    output logic [NUM_PAD-1:0] iopad_inpad,
    input  logic               ccff_head,
    input  logic               ccff_shift_en,
    input  logic               cfg_load,
    output logic               ccff_tail,
    output logic               cfg_valid,
    output logic [CNT_W-1:0]   cfg_shift_count
);
    logic [L-1:0] chain;
    logic [L-1:0] cfg;
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            chain           <= '0;
            cfg_valid       <= 1'b0;
            cfg_shift_count <= '0;
        end else begin
            if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
            cfg_valid       <= ccff_shift_en ? 1'b0 : (cfg_load | cfg_valid);
            cfg_shift_count <= cfg_load ? '0 :
                               (ccff_shift_en && cfg_shift_count != CNT_W'(L)) ? cfg_shift_count + 1'b1 :
                               cfg_shift_count;
        end
    end
    assign ccff_tail = chain[L-1];
`ifdef GPIO_SHADOW_EN
    logic [L-1:0] shadow;
    always_ff @(posedge prog_clk) begin
        if (pReset) shadow <= '0;
        else if (cfg_load) shadow <= chain;
    end
    assign cfg = shadow;
`else
    assign cfg = chain;
`endif
    for (genvar k = 0; k < NUM_PAD; k++) begin : g_pad
        assign gfpga_pad_GPIO_PAD[k] = cfg[CFG_BITS*k] ? (iopad_outpad[k] ^ cfg[CFG_BITS*k+1]) : 1'bz;
        assign iopad_inpad[k]        = gfpga_pad_GPIO_PAD[k] ^ cfg[CFG_BITS*k+2];
    end
endmodule
